// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width and the 4-bit operation select codes.
package alu_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRA  = 4'd6;
   localparam logic [3:0] ALU_SRL  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between NREQ ALU requesters and the shared-ALU arbiter.
// Requester i's fields sit at slice i of the packed request vectors.
interface alu_arbiter_if #(
   parameter int NREQ = 2,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
);
   import alu_pkg::*;

   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*XLEN-1:0] req_a;
   logic [NREQ*XLEN-1:0] req_b;
   logic [NREQ*4-1:0]    req_sel;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [XLEN-1:0]      resp_data;
   logic [IDW-1:0]       resp_id;

   // Requesters plus result consumer
   modport master (
      output req_valid, req_a, req_b, req_sel, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_id
   );

   // Arbiter side
   modport slave (
      input  req_valid, req_a, req_b, req_sel, resp_ready,
      output req_ready, resp_valid, resp_data, resp_id
   );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Single-cycle combinational 32-bit integer ALU. Unused select codes execute as ADD.
module alu_arbiter_alu
   import alu_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [3:0]      sel,
   output logic [XLEN-1:0] y
);

   logic signed [XLEN-1:0] sa;
   logic signed [XLEN-1:0] sb;
   logic [4:0]             shamt;

   assign sa    = a;
   assign sb    = b;
   assign shamt = b[4:0];

   // Operation decode; select codes 10..15 fall through to ADD
   always_comb begin
      y = a + b;
      case (sel)
         ALU_SUB:  y = a - b;
         ALU_SLL:  y = a << shamt;
         ALU_SLT:  y = {{(XLEN-1){1'b0}}, (sa < sb)};
         ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
         ALU_XOR:  y = a ^ b;
         ALU_SRA:  y = $unsigned(sa >>> shamt);
         ALU_SRL:  y = a >> shamt;
         ALU_OR:   y = a | b;
         ALU_AND:  y = a & b;
         default:  y = a + b;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters.
// One operation is granted per cycle into a one-entry result register that
// is returned with the index of the requester that issued it.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic clk,
   input  logic rst_n,
   alu_arbiter_if.slave bus
);

   logic            can_issue;
   logic [NREQ-1:0] gnt;
   logic [IDW-1:0]  gidx;
   logic            gnt_any;
   logic [IDW-1:0]  idx;
   int              j;
   logic [IDW-1:0]  rr_ptr;

   logic [XLEN-1:0] mux_a;
   logic [XLEN-1:0] mux_b;
   logic [3:0]      mux_sel;
   logic [XLEN-1:0] alu_y;

   logic            vld_p1;
   logic [XLEN-1:0] data_p1;
   logic [IDW-1:0]  id_p1;

   // Issue is possible when the result slot is empty or drains this cycle;
   // gating with rst_n keeps req_ready low throughout reset.
   assign can_issue = rst_n && (!vld_p1 || bus.resp_ready);

   // Circular first-valid search starting at rr_ptr, yielding a one-hot grant
   always_comb begin
      gnt     = '0;
      gidx    = '0;
      gnt_any = 1'b0;
      idx     = '0;
      j       = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         idx = IDW'(j);
         if (!gnt_any && can_issue && bus.req_valid[idx]) begin
            gnt[idx] = 1'b1;
            gidx     = idx;
            gnt_any  = 1'b1;
         end
      end
   end

   // AND-OR operand/select mux steered by the one-hot grant
   always_comb begin
      mux_a   = '0;
      mux_b   = '0;
      mux_sel = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt[k]) begin
            mux_a   = mux_a   | bus.req_a[k*XLEN +: XLEN];
            mux_b   = mux_b   | bus.req_b[k*XLEN +: XLEN];
            mux_sel = mux_sel | bus.req_sel[k*4 +: 4];
         end
      end
   end

   alu_arbiter_alu u_alu (
      .a   (mux_a),
      .b   (mux_b),
      .sel (mux_sel),
      .y   (alu_y)
   );

   // Result register and round-robin pointer; a grant overwrites the slot
   // even when the old result drains on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         id_p1   <= '0;
         rr_ptr  <= '0;
      end else if (gnt_any) begin
         vld_p1  <= 1'b1;
         data_p1 <= alu_y;
         id_p1   <= gidx;
         rr_ptr  <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + 1'b1;
      end else if (bus.resp_ready) begin
         vld_p1  <= 1'b0;
      end
   end

   assign bus.req_ready  = gnt;
   assign bus.resp_valid = vld_p1;
   assign bus.resp_data  = data_p1;
   assign bus.resp_id    = id_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter with NREQ=2: reference ALU plus round-robin model
// feeding a result scoreboard queue.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int NREQ = 2;
   localparam int IDW  = 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   alu_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
   alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic [31:0] ta [NREQ];
   logic [31:0] tb [NREQ];
   logic [3:0]  ts [NREQ];

   always_comb begin
      bus.req_a   = '0;
      bus.req_b   = '0;
      bus.req_sel = '0;
      for (int k = 0; k < NREQ; k++) begin
         bus.req_a[k*32 +: 32] = ta[k];
         bus.req_b[k*32 +: 32] = tb[k];
         bus.req_sel[k*4 +: 4] = ts[k];
      end
   end

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [31:0]    data;
   } exp_t;

   exp_t            sbq[$];
   int              m_rr;
   logic [NREQ-1:0] exp_rdy;
   logic [NREQ-1:0] rdy_obs;
   int              total = 0;
   int              bad   = 0;

   function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] sel);
      logic [63:0] ext;
      int          sh;
      sh  = int'(b[4:0]);
      ext = {{32{a[31]}}, a} >> sh;
      case (sel)
         4'd1:    return a + ~b + 32'd1;
         4'd2:    return a << sh;
         4'd3:    return (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, (a < b)};
         4'd4:    return {31'd0, (a < b)};
         4'd5:    return a ^ b;
         4'd6:    return ext[31:0];
         4'd7:    return a >> sh;
         4'd8:    return a | b;
         4'd9:    return a & b;
         default: return a + b;
      endcase
   endfunction

   // One clock: capture req_ready mid-cycle, advance the model, land #1 after the edge
   task automatic tick();
      logic can;
      logic found;
      int   g;
      exp_t e;
      @(negedge clk);
      rdy_obs = bus.req_ready;
      exp_rdy = '0;
      found   = 1'b0;
      g       = 0;
      if (!rst_n) begin
         sbq.delete();
         m_rr = 0;
      end else begin
         can = (sbq.size() == 0) || bus.resp_ready;
         if (can) begin
            for (int k = 0; k < NREQ; k++) begin
               if (!found && bus.req_valid[(m_rr + k) % NREQ]) begin
                  found = 1'b1;
                  g     = (m_rr + k) % NREQ;
               end
            end
         end
         if (sbq.size() != 0 && bus.resp_ready) void'(sbq.pop_front());
         if (found) begin
            e.id   = IDW'(g);
            e.data = ref_alu(ta[g], tb[g], ts[g]);
            sbq.push_back(e);
            exp_rdy[g] = 1'b1;
            m_rr = (g + 1) % NREQ;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.req_valid  = '1;
      bus.resp_ready = 1'b1;
      ta[0] = 32'd10; tb[0] = 32'd3; ts[0] = 4'd1;
      ta[1] = 32'd7;  tb[1] = 32'd9; ts[1] = 4'd0;
      tick();
      total++; if (rdy_obs !== 2'b00) begin bad++; $display("FAIL reset_ready: got %b want 00", rdy_obs); end
      total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.resp_valid); end
      total++; if (bus.resp_data !== 32'd0) begin bad++; $display("FAIL reset_data: got %h want 0", bus.resp_data); end
      total++; if (bus.resp_id !== 1'b0) begin bad++; $display("FAIL reset_id: got %0d want 0", bus.resp_id); end
      rst_n = 1'b1;
      tick();
      total++; if (rdy_obs !== 2'b01) begin bad++; $display("FAIL first_grant: got %b want 01", rdy_obs); end
      total++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_data !== sbq[0].data) begin
         bad++; $display("FAIL first_result: got v=%b id=%0d d=%h want v=1 id=0 d=%h",
                         bus.resp_valid, bus.resp_id, bus.resp_data, sbq[0].data);
      end
   endtask

   task automatic test_single();
      bus.req_valid = 2'b10;
      ta[1] = 32'h0000_0005; tb[1] = 32'hFFFF_FFFF; ts[1] = 4'd3;
      tick();
      total++; if (rdy_obs !== exp_rdy) begin bad++; $display("FAIL slt_ready: got %b want %b", rdy_obs, exp_rdy); end
      total++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd0 || bus.resp_id !== 1'b1) begin
         bad++; $display("FAIL slt_result: got v=%b d=%h id=%0d want v=1 d=0 id=1",
                         bus.resp_valid, bus.resp_data, bus.resp_id);
      end
      ts[1] = 4'd4;
      tick();
      total++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== 32'd1 || bus.resp_id !== 1'b1) begin
         bad++; $display("FAIL sltu_result: got v=%b d=%h id=%0d want v=1 d=1 id=1",
                         bus.resp_valid, bus.resp_data, bus.resp_id);
      end
   endtask

   task automatic test_alu_ops();
      logic [3:0]  sels [4] = '{4'd6, 4'd7, 4'd2, 4'd12};
      logic [31:0] want [4] = '{32'hC000_0000, 32'h4000_0000, 32'h0000_0000, 32'h8000_0021};
      bus.req_valid = 2'b01;
      ta[0] = 32'h8000_0000; tb[0] = 32'h0000_0021;
      for (int i = 0; i < 4; i++) begin
         ts[0] = sels[i];
         tick();
         total++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== want[i] || bus.resp_id !== 1'b0) begin
            bad++; $display("FAIL alu_sel%0d: got v=%b d=%h id=%0d want v=1 d=%h id=0",
                            sels[i], bus.resp_valid, bus.resp_data, bus.resp_id, want[i]);
         end
      end
      for (int i = 0; i < 8; i++) begin
         ta[0] = $urandom; tb[0] = $urandom; ts[0] = 4'(i + 1);
         tick();
         total++; if (bus.resp_data !== sbq[0].data) begin
            bad++; $display("FAIL alu_rand_sel%0d: got %h want %h", ts[0], bus.resp_data, sbq[0].data);
         end
      end
   endtask

   task automatic test_fairness();
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      sbq.delete();
      m_rr = 0;
      bus.req_valid  = 2'b11;
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < NREQ; k++) begin
            ta[k] = $urandom; tb[k] = $urandom; ts[k] = 4'($urandom_range(0, 15));
         end
         tick();
         total++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== IDW'(i % 2) || bus.resp_data !== sbq[0].data) begin
            bad++; $display("FAIL fair_%0d: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                            i, bus.resp_valid, bus.resp_id, bus.resp_data, i % 2, sbq[0].data);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0]    hold_d;
      logic [IDW-1:0] hold_i;
      bus.req_valid  = 2'b11;
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      hold_d = bus.resp_data;
      hold_i = bus.resp_id;
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < NREQ; k++) begin
            ta[k] = $urandom; tb[k] = $urandom; ts[k] = 4'($urandom_range(0, 9));
         end
         tick();
         total++; if (rdy_obs !== 2'b00) begin bad++; $display("FAIL bp_ready_%0d: got %b want 00", i, rdy_obs); end
         total++; if (bus.resp_valid !== 1'b1 || bus.resp_data !== hold_d || bus.resp_id !== hold_i) begin
            bad++; $display("FAIL bp_hold_%0d: got v=%b d=%h id=%0d want v=1 d=%h id=%0d",
                            i, bus.resp_valid, bus.resp_data, bus.resp_id, hold_d, hold_i);
         end
      end
      bus.resp_ready = 1'b1;
      tick();
      total++; if (rdy_obs !== exp_rdy || !$onehot(rdy_obs)) begin
         bad++; $display("FAIL bp_release_ready: got %b want %b", rdy_obs, exp_rdy);
      end
      total++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== sbq[0].id || bus.resp_data !== sbq[0].data) begin
         bad++; $display("FAIL bp_release_result: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                         bus.resp_valid, bus.resp_id, bus.resp_data, sbq[0].id, sbq[0].data);
      end
   endtask

   task automatic test_async_reset();
      bus.req_valid  = 2'b11;
      bus.resp_ready = 1'b1;
      ta[0] = 32'h1234_0000; tb[0] = 32'h0000_5678; ts[0] = 4'd8;
      ta[1] = 32'h0F0F_0F0F; tb[1] = 32'hFFFF_0000; ts[1] = 4'd9;
      tick();
      bus.resp_ready = 1'b0;
      tick();
      total++; if (bus.resp_valid !== 1'b1) begin bad++; $display("FAIL ar_pending: got v=%b want 1", bus.resp_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (bus.resp_valid !== 1'b0 || bus.resp_data !== 32'd0) begin
         bad++; $display("FAIL ar_immediate: got v=%b d=%h want v=0 d=0", bus.resp_valid, bus.resp_data);
      end
      total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL ar_ready: got %b want 00", bus.req_ready); end
      sbq.delete();
      m_rr = 0;
      bus.req_valid = 2'b00;
      tick();
      rst_n = 1'b1;
      bus.resp_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         total++; if (bus.resp_valid !== 1'b0) begin bad++; $display("FAIL ar_no_resp_%0d: got v=%b want 0", i, bus.resp_valid); end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      m_rr = 0;
      bus.req_valid  = '0;
      bus.resp_ready = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         ta[k] = '0; tb[k] = '0; ts[k] = '0;
      end
      test_reset();
      test_single();
      test_alu_ops();
      test_fairness();
      test_backpressure();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
